// File: rtl/tmr_fault_supervisor_if.sv
// Replica vectors, injection handshake and supervisor status between system control and the TMR supervisor.
// slave = supervisor side, master = system/requester side.
interface tmr_fault_supervisor_if #(
    parameter int WIDTH = 27,
    parameter int LEN_W = 8
);
    logic [WIDTH-1:0] data_A;
    logic [WIDTH-1:0] data_B;
    logic [WIDTH-1:0] data_C;
    logic             inj_req;
    logic [1:0]       inj_lane;
    logic [LEN_W-1:0] inj_len;
    logic             inj_ack;
    logic             inj_rej;
    logic             A_error_ctrl;
    logic             B_error_ctrl;
    logic             C_error_ctrl;
    logic [2:0]       lane_mismatch;
    logic [2:0]       lane_fail;
    logic             fail_clr;
    logic             resync_req;
    logic             resync_ack;
    logic             fatal;
    logic [15:0]      err_cnt;

    modport slave (
        input  data_A, data_B, data_C, inj_req, inj_lane, inj_len, fail_clr, resync_ack,
        output inj_ack, inj_rej, A_error_ctrl, B_error_ctrl, C_error_ctrl,
               lane_mismatch, lane_fail, resync_req, fatal, err_cnt
    );

    modport master (
        output data_A, data_B, data_C, inj_req, inj_lane, inj_len, fail_clr, resync_ack,
        input  inj_ack, inj_rej, A_error_ctrl, B_error_ctrl, C_error_ctrl,
               lane_mismatch, lane_fail, resync_req, fatal, err_cnt
    );
endinterface

// File: rtl/tmr_fault_supervisor.sv
// TMR supervisor: majority-compare replicas, track lane failures, sequence fault-injection campaigns.
// Latency: mismatch 1 cycle, ack combinational in IDLE; requester holds inj_req until ack, resync_req held until resync_ack.
module tmr_fault_supervisor #(
    parameter int WIDTH       = 27,
    parameter int FAIL_THRESH = 4,
    parameter int RECOV_MAX   = 16,
    parameter int LEN_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    tmr_fault_supervisor_if.slave  bus
);
    localparam int CNT_W = $clog2(FAIL_THRESH + 1);
    localparam int TMR_W = $clog2(RECOV_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INJECT,
        S_RECOVER,
        S_RESYNC,
        S_FATAL
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              lane_q, lane_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [TMR_W-1:0]        tmr_q, tmr_d;
    logic                    ok_q, ok_d;
    logic                    req_seen_q, req_seen_d;
    logic [2:0]              mism_q, mism_d;
    logic [2:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]              fail_q, fail_d;
    logic                    fatal_q, fatal_d;
    logic [15:0]             err_q, err_d;

    logic [WIDTH-1:0]        maj;
    logic                    distinct;
    logic [2:0]              fail_set;
    logic [2:0]              resync_clr;
    logic [2:0]              ctrl;
    logic                    ack, rej, resync_req;

    // Voting datapath and lane health tracking
    always_comb begin
        maj      = (bus.data_A & bus.data_B) | (bus.data_B & bus.data_C) | (bus.data_A & bus.data_C);
        mism_d   = {bus.data_C != maj, bus.data_B != maj, bus.data_A != maj};
        distinct = (bus.data_A != bus.data_B) && (bus.data_B != bus.data_C) && (bus.data_A != bus.data_C);
        fatal_d  = fatal_q | distinct;
        err_d    = err_q;
        if (|mism_q && err_q != 16'hFFFF) begin
            err_d = err_q + 16'd1;
        end
        cnt_d    = '0;
        fail_set = '0;
        for (int i = 0; i < 3; i++) begin
            if (mism_q[i]) begin
                cnt_d[i] = (cnt_q[i] == CNT_W'(FAIL_THRESH)) ? cnt_q[i] : cnt_q[i] + 1'b1;
            end
            fail_set[i] = (cnt_q[i] == CNT_W'(FAIL_THRESH));
        end
        // A fresh failure beats any clear arriving in the same cycle
        fail_d = (fail_q & ~({3{bus.fail_clr}} | resync_clr)) | fail_set;
    end

    // Campaign sequencer
    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        len_d      = len_q;
        tmr_d      = tmr_q;
        ok_d       = ok_q;
        req_seen_d = req_seen_q & bus.inj_req;
        ack        = 1'b0;
        rej        = 1'b0;
        resync_clr = '0;
        resync_req = 1'b0;
        ctrl       = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.inj_req && !req_seen_q) begin
                    ack        = 1'b1;
                    req_seen_d = 1'b1;
                    if (bus.inj_lane == 2'd3 || bus.inj_len == '0 || |fail_q || fatal_d) begin
                        rej = 1'b1;
                    end else begin
                        lane_d  = bus.inj_lane;
                        len_d   = bus.inj_len;
                        state_d = S_INJECT;
                    end
                end
            end
            S_INJECT: begin
                ctrl = 3'b001 << lane_q;
                if (len_q == LEN_W'(1)) begin
                    state_d = S_RECOVER;
                    tmr_d   = '0;
                    ok_d    = 1'b0;
                end else begin
                    len_d = len_q - 1'b1;
                end
            end
            S_RECOVER: begin
                tmr_d = tmr_q + 1'b1;
                ok_d  = !mism_q[lane_q];
                if (!mism_q[lane_q] && ok_q) begin
                    state_d = S_IDLE;
                end else if (tmr_q == TMR_W'(RECOV_MAX - 1)) begin
                    state_d = S_RESYNC;
                end
            end
            S_RESYNC: begin
                resync_req = 1'b1;
                if (bus.resync_ack) begin
                    resync_clr = 3'b001 << lane_q;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_FATAL;
            end
        endcase
        if (fatal_d) begin
            state_d = S_FATAL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            lane_q     <= '0;
            len_q      <= '0;
            tmr_q      <= '0;
            ok_q       <= 1'b0;
            req_seen_q <= 1'b0;
            mism_q     <= '0;
            cnt_q      <= '0;
            fail_q     <= '0;
            fatal_q    <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            len_q      <= len_d;
            tmr_q      <= tmr_d;
            ok_q       <= ok_d;
            req_seen_q <= req_seen_d;
            mism_q     <= mism_d;
            cnt_q      <= cnt_d;
            fail_q     <= fail_d;
            fatal_q    <= fatal_d;
            err_q      <= err_d;
        end
    end

    assign bus.inj_ack       = ack;
    assign bus.inj_rej       = rej;
    assign bus.A_error_ctrl  = ctrl[0];
    assign bus.B_error_ctrl  = ctrl[1];
    assign bus.C_error_ctrl  = ctrl[2];
    assign bus.lane_mismatch = mism_q;
    assign bus.lane_fail     = fail_q;
    assign bus.resync_req    = resync_req;
    assign bus.fatal         = fatal_q;
    assign bus.err_cnt       = err_q;
endmodule

// File: tb/tb_tmr_fault_supervisor.sv
// Scoreboarded bench for tmr_fault_supervisor: stimulus queues expected acks, injection pulses and resync timing;
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_tmr_fault_supervisor;
    localparam logic [26:0] BASE = 27'h0123456;
    localparam logic [26:0] FLIP = 27'h0000100;

    typedef struct {
        int lane;
        int len;
    } pulse_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [26:0] va = BASE, vb = BASE, vc = BASE;
    logic [2:0]  stuck = 3'b000;
    int          n_chk = 0;
    int          n_fail = 0;
    int          exp_err = 0;

    bit          ack_q[$];
    pulse_t      pulse_q[$];
    int          resync_q[$];

    tmr_fault_supervisor_if #(.WIDTH(27), .LEN_W(8)) bus ();

    tmr_fault_supervisor #(
        .WIDTH(27), .FAIL_THRESH(4), .RECOV_MAX(16), .LEN_W(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Replicas follow their error_ctrl line (fault tracking) or a stuck flag
    assign bus.data_A = va ^ ((bus.A_error_ctrl || stuck[0]) ? FLIP : 27'd0);
    assign bus.data_B = vb ^ ((bus.B_error_ctrl || stuck[1]) ? FLIP : 27'd0);
    assign bus.data_C = vc ^ ((bus.C_error_ctrl || stuck[2]) ? FLIP : 27'd0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] all_outs();
        return {5'd0, bus.inj_ack, bus.inj_rej, bus.A_error_ctrl, bus.B_error_ctrl, bus.C_error_ctrl,
                bus.lane_mismatch, bus.lane_fail, bus.resync_req, bus.fatal, bus.err_cnt};
    endfunction

    // Issue a request; when an ack is expected hold inj_req until it is seen, then drop for a cycle
    task automatic do_req(input logic [1:0] lane, input logic [7:0] len, input bit exp_ack);
        bit got = 0;
        bus.inj_lane = lane;
        bus.inj_len  = len;
        bus.inj_req  = 1'b1;
        #1;
        if (exp_ack) begin
            for (int i = 0; i < 20; i++) begin
                if (bus.inj_ack) begin
                    got = 1;
                    break;
                end
                cyc(1);
            end
            if (!got) chk("ack_timeout", 0, 1);
            cyc(1);
        end else begin
            cyc(5);
        end
        bus.inj_req = 1'b0;
        cyc(1);
    endtask

    // Mismatch on replica B for n consecutive input cycles
    task automatic b_bad(input int n);
        vb = BASE ^ 27'h0000F00;
        cyc(n);
        vb = BASE;
    endtask

    initial begin
        int     run_len = 0;
        int     run_lane = 0;
        int     since_fall = 0;
        bit     rs_prev = 0;
        pulse_t p;

        bus.inj_req    = 1'b0;
        bus.inj_lane   = 2'd0;
        bus.inj_len    = 8'd0;
        bus.fail_clr   = 1'b0;
        bus.resync_ack = 1'b0;

        fork
            forever begin
                logic [2:0] c;
                @(negedge clk);
                c = {bus.C_error_ctrl, bus.B_error_ctrl, bus.A_error_ctrl};
                if (bus.inj_ack) begin
                    if (ack_q.size() == 0) chk("unexpected_ack", 1, 0);
                    else chk("inj_rej", {31'd0, bus.inj_rej}, {31'd0, ack_q.pop_front()});
                end
                if (c != 3'b000) begin
                    chk("ctrl_onehot", $countones(c), 1);
                    run_lane = (c == 3'b001) ? 0 : (c == 3'b010) ? 1 : 2;
                    run_len++;
                    since_fall = 0;
                end else if (run_len != 0) begin
                    if (pulse_q.size() == 0) begin
                        chk("unexpected_pulse", run_len, 0);
                    end else begin
                        p = pulse_q.pop_front();
                        chk("pulse_lane", run_lane, p.lane);
                        chk("pulse_len", run_len, p.len);
                    end
                    run_len = 0;
                    since_fall = 1;
                end else if (since_fall != 0) begin
                    since_fall++;
                end
                if (bus.resync_req && !rs_prev) begin
                    if (resync_q.size() == 0) chk("unexpected_resync", 1, 0);
                    else chk("resync_delay", since_fall, resync_q.pop_front());
                end
                rs_prev = bus.resync_req;
            end
        join_none

        // Reset state
        cyc(2);
        chk("reset_outputs", all_outs(), 0);
        rst = 1'b0;

        // Clean replicas
        cyc(20);
        chk("clean_mismatch", bus.lane_mismatch, 0);
        chk("clean_err", bus.err_cnt, 0);
        chk("clean_fail", bus.lane_fail, 0);
        chk("clean_fatal", bus.fatal, 0);

        // B bad 4 cycles: fail set two edges after mismatch ends
        vb = BASE ^ 27'h0000F00;
        cyc(1);
        chk("b_mismatch_first", bus.lane_mismatch, 3'b010);
        cyc(3);
        chk("b_mismatch_hold", bus.lane_mismatch, 3'b010);
        vb = BASE;
        cyc(1);
        chk("b_fail_not_yet", bus.lane_fail, 0);
        cyc(1);
        chk("b_fail_set", bus.lane_fail, 3'b010);
        chk("b_err4", bus.err_cnt, 4);
        bus.fail_clr = 1'b1;
        cyc(1);
        bus.fail_clr = 1'b0;
        chk("fail_clr", bus.lane_fail, 0);

        // Three mismatch cycles stay below the threshold
        b_bad(3);
        cyc(3);
        chk("below_thresh", bus.lane_fail, 0);
        chk("err7", bus.err_cnt, 7);

        // Set beats a concurrent fail_clr
        bus.fail_clr = 1'b1;
        b_bad(4);
        cyc(2);
        chk("set_wins", bus.lane_fail, 3'b010);
        cyc(1);
        bus.fail_clr = 1'b0;
        chk("clr_after_set", bus.lane_fail, 0);
        exp_err = 11;

        // Inject C for 5 cycles, C re-converges
        ack_q.push_back(0);
        pulse_q.push_back('{2, 5});
        do_req(2'd2, 8'd5, 1);
        cyc(12);
        chk("c_fail_during_inject", bus.lane_fail, 3'b100);
        chk("c_no_resync", bus.resync_req, 0);
        exp_err += 5;
        chk("err_after_c", bus.err_cnt, exp_err);
        bus.fail_clr = 1'b1;
        cyc(1);
        bus.fail_clr = 1'b0;

        // Rejections
        ack_q.push_back(1);
        do_req(2'd3, 8'd5, 1);
        ack_q.push_back(1);
        do_req(2'd0, 8'd0, 1);
        b_bad(4);
        cyc(2);
        chk("pre_rej_fail", bus.lane_fail, 3'b010);
        ack_q.push_back(1);
        do_req(2'd0, 8'd3, 1);
        exp_err += 4;
        chk("err_after_rej", bus.err_cnt, exp_err);
        bus.fail_clr = 1'b1;
        cyc(1);
        bus.fail_clr = 1'b0;

        // Inject A, A never re-converges: resync after RECOV_MAX recover cycles (seen on the 17th negedge after ctrl falls)
        ack_q.push_back(0);
        pulse_q.push_back('{0, 3});
        resync_q.push_back(17);
        do_req(2'd0, 8'd3, 1);
        stuck[0] = 1'b1;
        for (int i = 0; i < 40 && !bus.resync_req; i++) cyc(1);
        chk("resync_seen", bus.resync_req, 1);
        cyc(3);
        chk("resync_held", bus.resync_req, 1);
        stuck[0] = 1'b0;
        cyc(3);
        chk("a_failed", bus.lane_fail, 3'b001);
        bus.resync_ack = 1'b1;
        cyc(1);
        bus.resync_ack = 1'b0;
        chk("resync_clears_fail", bus.lane_fail, 0);
        chk("resync_dropped", bus.resync_req, 0);

        // Back in IDLE: single-cycle injection on B accepted
        ack_q.push_back(0);
        pulse_q.push_back('{1, 1});
        do_req(2'd1, 8'd1, 1);
        cyc(8);
        chk("b_len1_no_fail", bus.lane_fail, 0);
        chk("b_len1_no_resync", bus.resync_req, 0);

        // All replicas distinct for one cycle
        va = BASE ^ 27'h0000001;
        vb = BASE ^ 27'h0000002;
        cyc(1);
        va = BASE;
        vb = BASE;
        chk("fatal_set", bus.fatal, 1);
        do_req(2'd0, 8'd3, 0);
        chk("fatal_sticky", bus.fatal, 1);
        chk("fatal_no_ctrl", {bus.C_error_ctrl, bus.B_error_ctrl, bus.A_error_ctrl}, 0);

        // Reset clears fatal; then reset mid-INJECT
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(1);
        chk("rst_clears_fatal", bus.fatal, 0);
        chk("rst_clears_err", bus.err_cnt, 0);
        ack_q.push_back(0);
        pulse_q.push_back('{2, 3});
        do_req(2'd2, 8'd10, 1);
        cyc(2);
        chk("mid_inject_ctrl", {bus.C_error_ctrl, bus.B_error_ctrl, bus.A_error_ctrl}, 3'b100);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_outputs", all_outs(), 0);
        cyc(2);
        rst = 1'b0;
        cyc(3);

        chk("ack_q_empty", ack_q.size(), 0);
        chk("pulse_q_empty", pulse_q.size(), 0);
        chk("resync_q_empty", resync_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
